// File: rtl/lives_manager_pkg.sv
// Shared game definitions: lives-manager state encoding, default life count
// and the lives width shared with the lives-icon renderer.
package lives_manager_pkg;

    localparam int unsigned LIVES_W        = 10;
    localparam int unsigned GAME_MAX_LIVES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GRACE,
        ST_OVER
    } state_t;

    function automatic logic [LIVES_W-1:0] sat_inc(
        input logic [LIVES_W-1:0] value,
        input logic [LIVES_W-1:0] ceiling
    );
        return (value >= ceiling) ? ceiling : value + 1'b1;
    endfunction

endpackage

// File: rtl/grace_timer.sv
// Post-hit invulnerability timer: counts frame ticks, signals the end of the
// window and drives the blinking player sprite mask.
module grace_timer #(
    parameter int unsigned GRACE_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic Pclk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic frame_tick,
    input  logic hold_vis,
    output logic done,
    output logic player_vis
);

    localparam int unsigned CNT_W   = $clog2(GRACE_FRAMES + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0]   cnt;
    logic [BLINK_W-1:0] blink_cnt;

    // Combinational so the owner can leave grace on the edge sampling the last tick.
    assign done = frame_tick && (cnt == CNT_W'(GRACE_FRAMES - 1));

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            blink_cnt  <= '0;
            player_vis <= 1'b1;
        end else if (clear) begin
            cnt        <= '0;
            blink_cnt  <= '0;
            player_vis <= 1'b0;
        end else if (enable) begin
            if (frame_tick) begin
                if (cnt != CNT_W'(GRACE_FRAMES))
                    cnt <= cnt + 1'b1;
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt  <= '0;
                    player_vis <= ~player_vis;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end else begin
            cnt        <= '0;
            blink_cnt  <= '0;
            player_vis <= hold_vis;
        end
    end

endmodule

// File: rtl/lives_manager.sv
// Player life bookkeeping: game-start load, hit decrement, saturating bonus,
// and the IDLE/PLAY/GRACE/OVER control that drives the grace timer.
module lives_manager
    import lives_manager_pkg::*;
#(
    parameter int unsigned MAX_LIVES    = GAME_MAX_LIVES,
    parameter int unsigned GRACE_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic               Pclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic               bonus,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               grace,
    output logic               player_vis,
    output logic               life_lost
);

    localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(MAX_LIVES);

    state_t             state, state_n;
    logic [LIVES_W-1:0] lives_n;
    logic               lost_n;
    logic               tmr_done, tmr_clear, tmr_enable, tmr_hold;

    always_comb begin
        state_n = state;
        lives_n = lives;
        lost_n  = 1'b0;
        if (start) begin
            state_n = ST_IDLE;
            lives_n = LIVES_FULL;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_PLAY;
                    lives_n = LIVES_FULL;
                end
                ST_PLAY: begin
                    if (hit) begin
                        lost_n = 1'b1;
                        if (lives > 1) begin
                            // Decrement first, then a coincident bonus re-adds with saturation.
                            lives_n = bonus ? sat_inc(lives - 1'b1, LIVES_FULL) : lives - 1'b1;
                            state_n = ST_GRACE;
                        end else begin
                            lives_n = '0;
                            state_n = ST_OVER;
                        end
                    end else if (bonus) begin
                        lives_n = sat_inc(lives, LIVES_FULL);
                    end
                end
                ST_GRACE: begin
                    if (bonus)
                        lives_n = sat_inc(lives, LIVES_FULL);
                    if (tmr_done)
                        state_n = ST_PLAY;
                end
                ST_OVER: begin
                    lives_n = '0;
                end
                default: begin
                    state_n = ST_IDLE;
                    lives_n = LIVES_FULL;
                end
            endcase
        end
    end

    assign tmr_clear  = (state == ST_PLAY)  && (state_n == ST_GRACE);
    assign tmr_enable = (state == ST_GRACE) && (state_n == ST_GRACE);
    assign tmr_hold   = (state_n != ST_OVER);

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lives     <= LIVES_FULL;
            game_over <= 1'b0;
            grace     <= 1'b0;
            life_lost <= 1'b0;
        end else begin
            state     <= state_n;
            lives     <= lives_n;
            game_over <= (state_n == ST_OVER);
            grace     <= (state_n == ST_GRACE);
            life_lost <= lost_n;
        end
    end

    grace_timer #(
        .GRACE_FRAMES(GRACE_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_grace_timer (
        .Pclk       (Pclk),
        .rst_n      (rst_n),
        .clear      (tmr_clear),
        .enable     (tmr_enable),
        .frame_tick (frame_tick),
        .hold_vis   (tmr_hold),
        .done       (tmr_done),
        .player_vis (player_vis)
    );

endmodule

// File: tb/tb_lives_manager.sv
// Scoreboard bench for lives_manager: expected output vectors are queued as
// stimulus is driven and compared one cycle later.
module tb_lives_manager;

    logic       Pclk = 1'b0;
    logic       rst_n, start, frame_tick, hit, bonus;
    logic [9:0] lives;
    logic       game_over, grace, player_vis, life_lost;

    logic [13:0] obs;
    logic [13:0] exp_v;
    logic [13:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    assign obs = {lives, game_over, grace, player_vis, life_lost};

    always #20 Pclk = ~Pclk;

    lives_manager #(
        .MAX_LIVES    (4),
        .GRACE_FRAMES (120),
        .BLINK_FRAMES (8)
    ) dut (
        .Pclk       (Pclk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_tick (frame_tick),
        .hit        (hit),
        .bonus      (bonus),
        .lives      (lives),
        .game_over  (game_over),
        .grace      (grace),
        .player_vis (player_vis),
        .life_lost  (life_lost)
    );

    function automatic logic [13:0] mk(input int l, input logic go, input logic gr,
                                       input logic v, input logic ll);
        return {10'(l), go, gr, v, ll};
    endfunction

    function automatic logic blink(input int k);
        return ((k / 8) % 2) == 1;
    endfunction

    task automatic step(input logic h, input logic b, input logic t, input logic s);
        hit = h; bonus = b; frame_tick = t; start = s;
        @(posedge Pclk);
        #1;
        hit = 1'b0; bonus = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = 1'b0; hit = 1'b0; bonus = 1'b0; frame_tick = 1'b0;
        #5 rst_n = 1'b0;
        sb.push_back(mk(4, 0, 0, 1, 0));
        #1;
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset got %h want %h", obs, exp_v); end
        @(posedge Pclk); #1;
        rst_n = 1'b1;
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_play got %h want %h", obs, exp_v); end
    endtask

    task automatic test_grace;
        sb.push_back(mk(3, 0, 1, 0, 1));
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL first_hit got %h want %h", obs, exp_v); end
        for (int k = 1; k <= 120; k++) begin
            sb.push_back((k == 120) ? mk(3, 0, 0, 1, 0) : mk(3, 0, 1, blink(k), 0));
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL grace_tick k=%0d got %h want %h", k, obs, exp_v); end
            if (k == 10) begin
                sb.push_back(mk(3, 0, 1, blink(10), 0));
                step(1, 0, 0, 0);
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL hit_in_grace got %h want %h", obs, exp_v); end
            end
        end
        sb.push_back(mk(2, 0, 1, 0, 1));
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hit_after_grace got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_grace;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk(2, 0, 1, 0, 0));
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL pre_reset k=%0d got %h want %h", k, obs, exp_v); end
        end
        #10 rst_n = 1'b0;
        sb.push_back(mk(4, 0, 0, 1, 0));
        #1;
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset got %h want %h", obs, exp_v); end
        @(posedge Pclk); #1;
        sb.push_back(mk(4, 0, 0, 1, 0));
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_held got %h want %h", obs, exp_v); end
        #5 rst_n = 1'b1;
        @(posedge Pclk); #1;
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart_play got %h want %h", obs, exp_v); end
    endtask

    task automatic test_hit_bonus;
        sb.push_back(mk(4, 0, 1, 0, 1));
        step(1, 1, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hit_bonus got %h want %h", obs, exp_v); end
        sb.push_back(mk(4, 0, 1, 0, 0));
        step(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lost_one_cycle got %h want %h", obs, exp_v); end
        for (int k = 1; k <= 120; k++) begin
            sb.push_back((k == 120) ? mk(4, 0, 0, 1, 0) : mk(4, 0, 1, blink(k), 0));
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL hb_tick k=%0d got %h want %h", k, obs, exp_v); end
        end
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL bonus_saturate got %h want %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back;
        sb.push_back(mk(3, 0, 1, 0, 1));
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_first got %h want %h", obs, exp_v); end
        sb.push_back(mk(3, 0, 1, 0, 0));
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_second got %h want %h", obs, exp_v); end
        sb.push_back(mk(4, 0, 1, 0, 0));
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL bonus_in_grace got %h want %h", obs, exp_v); end
    endtask

    task automatic test_game_over;
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 0, 0, 1);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_to_idle got %h want %h", obs, exp_v); end
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL idle_to_play got %h want %h", obs, exp_v); end
        for (int h = 1; h <= 4; h++) begin
            sb.push_back((h < 4) ? mk(4 - h, 0, 1, 0, 1) : mk(0, 1, 0, 0, 1));
            step(1, 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL go_hit h=%0d got %h want %h", h, obs, exp_v); end
            if (h < 4) begin
                for (int k = 1; k <= 120; k++) begin
                    sb.push_back((k == 120) ? mk(4 - h, 0, 0, 1, 0) : mk(4 - h, 0, 1, blink(k), 0));
                    step(0, 0, 1, 0);
                    exp_v = sb.pop_front(); checks++;
                    if (obs !== exp_v) begin errors++; $display("FAIL go_tick h=%0d k=%0d got %h want %h", h, k, obs, exp_v); end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(0, 1, 0, 0, 0));
            step(i != 1, i != 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL over_ignore i=%0d got %h want %h", i, obs, exp_v); end
        end
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 0, 0, 1);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL over_to_idle got %h want %h", obs, exp_v); end
        sb.push_back(mk(4, 0, 0, 1, 0));
        step(0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL new_game got %h want %h", obs, exp_v); end
        sb.push_back(mk(3, 0, 1, 0, 1));
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL new_game_hit got %h want %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_grace();
        test_reset_mid_grace();
        test_hit_bonus();
        test_back_to_back();
        test_game_over();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
